// File: rtl/aclock_multi.sv
// BCD HH:MM:SS clock with N_AL independent alarm channels. Each channel has its own
// enable, snooze and auto-off, and all outputs are registered.
module aclock_multi #(
  parameter int TICKS_PER_SEC = 10,
  parameter int N_AL          = 4,
  parameter int SNOOZE_MIN    = 5,
  parameter int AUTO_OFF_MIN  = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      H_in1,
  input  logic [3:0]      H_in0,
  input  logic [3:0]      M_in1,
  input  logic [3:0]      M_in0,
  input  logic            LD_time,
  input  logic            LD_alarm,
  input  logic [2:0]      AL_SEL,
  input  logic [N_AL-1:0] AL_ON,
  input  logic            STOP_al,
  input  logic            SNOOZE,
  output logic            Alarm,
  output logic [N_AL-1:0] AL_RING,
  output logic [1:0]      H_out1,
  output logic [3:0]      H_out0,
  output logic [3:0]      M_out1,
  output logic [3:0]      M_out0,
  output logic [3:0]      S_out1,
  output logic [3:0]      S_out0
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  logic [TW-1:0] tick_q;
  logic [1:0]    h1_q, n_h1;
  logic [3:0]    h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0]    n_h0, n_m1, n_m0, n_s1, n_s0;
  logic          snooze_prev_q, alarm_q;
  logic [N_AL-1:0] ring_q, ring_d, snz_vld_q, snz_vld_d;
  logic [4:0]    alarm_h_q [N_AL];
  logic [5:0]    alarm_m_q [N_AL];
  logic [4:0]    snz_h_q   [N_AL];
  logic [5:0]    snz_m_q   [N_AL];
  logic [4:0]    snz_h_d   [N_AL];
  logic [5:0]    snz_m_d   [N_AL];
  logic [7:0]    aoff_q    [N_AL];
  logic [7:0]    aoff_d    [N_AL];

  logic       in_valid, ld_time_ok, ld_alarm_ok, tick_end, s_carry, m_carry;
  logic       minute_ev, snz_press;
  logic [4:0] in_h, cur_h, new_h, snz_tgt_h;
  logic [5:0] in_m, cur_m, new_m, snz_tgt_m;
  logic [6:0] snz_sum_m;

  assign in_valid = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
                    ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
  assign ld_time_ok  = LD_time && in_valid;
  assign ld_alarm_ok = LD_alarm && in_valid && (int'(AL_SEL) < N_AL);
  assign tick_end    = (tick_q == TICK_LAST);
  assign s_carry     = (s1_q == 4'd5) && (s0_q == 4'd9);
  assign m_carry     = s_carry && (m1_q == 4'd5) && (m0_q == 4'd9);
  // A load overrides the tick, so it can never produce a minute event.
  assign minute_ev   = tick_end && s_carry && !ld_time_ok;
  assign snz_press   = SNOOZE && !snooze_prev_q;

  // Alarm and snooze times are kept in binary so the snooze add wraps with plain arithmetic.
  assign in_h  = 5'(H_in1) * 5'd10 + 5'(H_in0);
  assign in_m  = 6'(M_in1) * 6'd10 + 6'(M_in0);
  assign cur_h = 5'(h1_q) * 5'd10 + 5'(h0_q);
  assign cur_m = 6'(m1_q) * 6'd10 + 6'(m0_q);
  assign new_h = 5'(n_h1) * 5'd10 + 5'(n_h0);
  assign new_m = 6'(n_m1) * 6'd10 + 6'(n_m0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    n_s0 = (s0_q == 4'd9) ? 4'd0 : s0_q + 4'd1;
    n_s1 = s1_q;
    n_m0 = m0_q;
    n_m1 = m1_q;
    n_h0 = h0_q;
    n_h1 = h1_q;
    if (s0_q == 4'd9) n_s1 = (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
    if (s_carry) begin
      n_m0 = (m0_q == 4'd9) ? 4'd0 : m0_q + 4'd1;
      if (m0_q == 4'd9) n_m1 = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
    end
    if (m_carry) begin
      if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
        n_h1 = 2'd0;
        n_h0 = 4'd0;
      end else if (h0_q == 4'd9) begin
        n_h1 = h1_q + 2'd1;
        n_h0 = 4'd0;
      end else begin
        n_h0 = h0_q + 4'd1;
      end
    end
  end

  always_comb begin
    snz_sum_m = 7'(cur_m) + 7'(SNOOZE_MIN);
    snz_tgt_h = cur_h;
    snz_tgt_m = snz_sum_m[5:0];
    if (snz_sum_m >= 7'd60) begin
      snz_tgt_m = 6'(snz_sum_m - 7'd60);
      snz_tgt_h = (cur_h == 5'd23) ? 5'd0 : cur_h + 5'd1;
    end
  end

  // Later assignments win: trigger/auto-off, then snooze, then channel load, enable, stop.
  always_comb begin
    ring_d    = ring_q;
    snz_vld_d = snz_vld_q;
    for (int i = 0; i < N_AL; i++) begin
      snz_h_d[i] = snz_h_q[i];
      snz_m_d[i] = snz_m_q[i];
      aoff_d[i]  = aoff_q[i];
      if (minute_ev && AL_ON[i]) begin
        if (snz_vld_q[i] && (new_h == snz_h_q[i]) && (new_m == snz_m_q[i])) begin
          snz_vld_d[i] = 1'b0;
          ring_d[i]    = 1'b1;
          aoff_d[i]    = 8'd0;
        end else if ((new_h == alarm_h_q[i]) && (new_m == alarm_m_q[i])) begin
          ring_d[i] = 1'b1;
          aoff_d[i] = 8'd0;
        end else if (ring_q[i] && (AUTO_OFF_MIN != 0)) begin
          aoff_d[i] = aoff_q[i] + 8'd1;
          if (aoff_d[i] == 8'(AUTO_OFF_MIN)) ring_d[i] = 1'b0;
        end
      end
      if (snz_press && ring_q[i]) begin
        ring_d[i]    = 1'b0;
        snz_vld_d[i] = 1'b1;
        snz_h_d[i]   = snz_tgt_h;
        snz_m_d[i]   = snz_tgt_m;
      end
      if ((ld_alarm_ok && (AL_SEL == 3'(i))) || !AL_ON[i] || STOP_al) begin
        ring_d[i]    = 1'b0;
        snz_vld_d[i] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q        <= '0;
      {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= '0;
      snooze_prev_q <= 1'b0;
      alarm_q       <= 1'b0;
      ring_q        <= '0;
      snz_vld_q     <= '0;
      // NOTE: the per-channel arrays are reset explicitly; they are small register files, not RAM.
      for (int i = 0; i < N_AL; i++) begin
        alarm_h_q[i] <= '0;
        alarm_m_q[i] <= '0;
        snz_h_q[i]   <= '0;
        snz_m_q[i]   <= '0;
        aoff_q[i]    <= '0;
      end
    end else begin
      snooze_prev_q <= SNOOZE;
      if (ld_time_ok) begin
        tick_q <= '0;
        {h1_q, h0_q, m1_q, m0_q} <= {H_in1, H_in0, M_in1, M_in0};
        {s1_q, s0_q} <= '0;
      end else if (tick_end) begin
        tick_q <= '0;
        {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
      end else begin
        tick_q <= tick_q + TW'(1);
      end
      for (int i = 0; i < N_AL; i++) begin
        if (ld_alarm_ok && (AL_SEL == 3'(i))) begin
          alarm_h_q[i] <= in_h;
          alarm_m_q[i] <= in_m;
        end
        snz_h_q[i] <= snz_h_d[i];
        snz_m_q[i] <= snz_m_d[i];
        aoff_q[i]  <= aoff_d[i];
      end
      ring_q    <= ring_d;
      snz_vld_q <= snz_vld_d;
      alarm_q   <= |ring_d;
    end
  end

  assign Alarm   = alarm_q;
  assign AL_RING = ring_q;
  assign H_out1  = h1_q;
  assign H_out0  = h0_q;
  assign M_out1  = m1_q;
  assign M_out0  = m0_q;
  assign S_out1  = s1_q;
  assign S_out0  = s0_q;

endmodule

// File: tb/tb_aclock_multi.sv
// Self-checking bench for aclock_multi: seconds-of-day / minutes-of-day model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_aclock_multi;

  localparam int TPS      = 2;
  localparam int NAL      = 4;
  localparam int SNZ      = 5;
  localparam int AOFF     = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [1:0] H_in1 = '0;
  logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0;
  logic LD_time = 1'b0, LD_alarm = 1'b0, STOP_al = 1'b0, SNOOZE = 1'b0;
  logic [2:0] AL_SEL = '0;
  logic [NAL-1:0] AL_ON = '0;
  logic Alarm;
  logic [NAL-1:0] AL_RING;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  int checks = 0;
  int errors = 0;

  aclock_multi #(.TICKS_PER_SEC(TPS), .N_AL(NAL), .SNOOZE_MIN(SNZ), .AUTO_OFF_MIN(AOFF)) dut (
    .clk(clk), .reset_n(reset_n), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_SEL(AL_SEL), .AL_ON(AL_ON),
    .STOP_al(STOP_al), .SNOOZE(SNOOZE), .Alarm(Alarm), .AL_RING(AL_RING),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [21:0] tvec();
    return {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  // ---------------- behavioural model ----------------
  int t_sec = 0, tick = 0;
  int al_min [NAL];
  int snz_min [NAL];
  int aoff [NAL];
  bit snz_v [NAL];
  logic [NAL-1:0] m_ring = '0, old_ring;
  bit snz_prev = 0, mev, press, in_ok;
  int hh, mm, old_min, new_min;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_sec = 0; tick = 0; m_ring = '0; snz_prev = 0;
      for (int i = 0; i < NAL; i++) begin
        al_min[i] = 0; snz_min[i] = 0; aoff[i] = 0; snz_v[i] = 0;
      end
    end else begin
      hh = int'(H_in1) * 10 + int'(H_in0);
      mm = int'(M_in1) * 10 + int'(M_in0);
      in_ok = (H_in0 <= 9) && (M_in0 <= 9) && (mm <= 59) && (hh <= 23);
      old_min = t_sec / 60;
      mev = 0;
      if (LD_time && in_ok) begin
        t_sec = hh * 3600 + mm * 60; tick = 0;
      end else if (tick == TPS - 1) begin
        tick = 0; t_sec = (t_sec + 1) % 86400; mev = (t_sec % 60 == 0);
      end else begin
        tick++;
      end
      new_min = t_sec / 60;
      press = SNOOZE && !snz_prev;
      snz_prev = SNOOZE;
      old_ring = m_ring;
      for (int i = 0; i < NAL; i++) begin
        if (mev && AL_ON[i]) begin
          if (snz_v[i] && new_min == snz_min[i]) begin
            snz_v[i] = 0; m_ring[i] = 1; aoff[i] = 0;
          end else if (new_min == al_min[i]) begin
            m_ring[i] = 1; aoff[i] = 0;
          end else if (old_ring[i] && AOFF > 0) begin
            aoff[i]++;
            if (aoff[i] == AOFF) m_ring[i] = 0;
          end
        end
        if (press && old_ring[i]) begin
          m_ring[i] = 0; snz_v[i] = 1; snz_min[i] = (old_min + SNZ) % 1440;
        end
        if (LD_alarm && in_ok && int'(AL_SEL) == i) begin
          m_ring[i] = 0; snz_v[i] = 0; al_min[i] = hh * 60 + mm;
        end
        if (!AL_ON[i] || STOP_al) begin
          m_ring[i] = 0; snz_v[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cycle_time", 32'(tvec()), 32'(bcd(t_sec / 3600, (t_sec / 60) % 60, t_sec % 60)));
    check("cycle_ring", 32'({Alarm, AL_RING}), 32'({|m_ring, m_ring}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_hm(input int h, input int m);
    H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
  endtask

  task automatic set_time(input int h, input int m);
    drive_hm(h, m); LD_time = 1; cyc(1); LD_time = 0;
  endtask

  task automatic set_alarm(input int sel, input int h, input int m);
    drive_hm(h, m); AL_SEL = 3'(sel); LD_alarm = 1; cyc(1); LD_alarm = 0;
  endtask

  task automatic wait_alarm(input string name, input logic want, input int budget);
    int n = 0;
    while (Alarm !== want && n < budget) begin cyc(1); n++; end
    check(name, 32'(Alarm), 32'(want));
  endtask

  task automatic stop_pulse();
    STOP_al = 1; cyc(1); STOP_al = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 0;
    cyc(20);
    reset_n = 1;
    check("reset_time", 32'(tvec()), 32'(bcd(0, 0, 0)));
    check("reset_ring", 32'({Alarm, AL_RING}), 32'h0);
    cyc(10 * TPS);
    check("ten_sec", 32'(tvec()), 32'(bcd(0, 0, 10)));

    set_time(23, 59);
    check("ld_time", 32'(tvec()), 32'(bcd(23, 59, 0)));
    cyc(120);
    check("day_wrap", 32'(tvec()), 32'(bcd(0, 0, 0)));
    H_in1 = 2'd2; H_in0 = 4'd5; M_in1 = 4'd0; M_in0 = 4'd0;
    LD_time = 1; cyc(1); LD_time = 0;
    check("ld_25h_ignored", 32'(tvec()), 32'(bcd(0, 0, 0)));
    cyc(1);
    check("ld_25h_tick_kept", 32'(tvec()), 32'(bcd(0, 0, 1)));
    H_in1 = 2'd1; H_in0 = 4'd2; M_in1 = 4'd6; M_in0 = 4'd0;
    LD_time = 1; cyc(1); LD_time = 0;
    check("ld_60m_ignored", 32'(tvec() >> 8), 32'(bcd(0, 0, 0) >> 8));

    AL_ON = 4'b0010;
    set_alarm(1, 11, 30);
    set_time(11, 29);
    cyc(119);
    check("al1_before", 32'(AL_RING), 32'h0);
    cyc(1);
    check("al1_ring", 32'({Alarm, AL_RING}), 32'b10010);
    check("al1_time", 32'(tvec()), 32'(bcd(11, 30, 0)));
    stop_pulse();
    check("al1_stop", 32'({Alarm, AL_RING}), 32'h0);

    AL_ON = 4'b1001;
    set_alarm(0, 6, 0);
    set_alarm(3, 6, 0);
    set_time(5, 59);
    wait_alarm("snz_first_ring", 1'b1, 130);
    check("snz_first_vec", 32'(AL_RING), 32'b1001);
    check("snz_first_time", 32'(tvec()), 32'(bcd(6, 0, 0)));
    SNOOZE = 1; cyc(1);
    check("snz_cleared", 32'({Alarm, AL_RING}), 32'h0);
    cyc(3); SNOOZE = 0;
    wait_alarm("snz_rering", 1'b1, 700);
    check("snz_rering_vec", 32'(AL_RING), 32'b1001);
    check("snz_rering_time", 32'(tvec()), 32'(bcd(6, 5, 0)));
    stop_pulse();

    set_alarm(0, 23, 58);
    set_alarm(3, 23, 58);
    set_time(23, 57);
    wait_alarm("mid_first_ring", 1'b1, 130);
    check("mid_first_time", 32'(tvec()), 32'(bcd(23, 58, 0)));
    SNOOZE = 1; cyc(1); SNOOZE = 0;
    check("mid_cleared", 32'(AL_RING), 32'h0);
    wait_alarm("mid_rering", 1'b1, 700);
    check("mid_rering_vec", 32'(AL_RING), 32'b1001);
    check("mid_rering_time", 32'(tvec()), 32'(bcd(0, 3, 0)));
    stop_pulse();

    AL_ON = 4'b0100;
    drive_hm(7, 0); AL_SEL = 3'd2; LD_alarm = 1; LD_time = 1; cyc(1);
    LD_alarm = 0; LD_time = 0;
    check("dual_load_time", 32'(tvec()), 32'(bcd(7, 0, 0)));
    check("dual_load_no_ring", 32'(AL_RING), 32'h0);
    set_time(6, 59);
    wait_alarm("aoff_ring", 1'b1, 130);
    check("aoff_ring_vec", 32'(AL_RING), 32'b0100);
    wait_alarm("aoff_fall", 1'b0, 400);
    check("aoff_fall_time", 32'(tvec()), 32'(bcd(7, 3, 0)));
    set_time(6, 59);
    wait_alarm("alon_ring", 1'b1, 130);
    AL_ON = 4'b0000; cyc(1);
    check("alon_off", 32'({Alarm, AL_RING}), 32'h0);
    AL_ON = 4'b0100;

    set_time(6, 59);
    cyc(115);
    STOP_al = 1; cyc(10); STOP_al = 0;
    check("stop_held_ring", 32'(AL_RING), 32'h0);
    check("stop_held_time", 32'(tvec()), 32'(bcd(7, 0, 2)));
    cyc(20);
    check("stop_held_after", 32'(Alarm), 32'h0);

    AL_ON = 4'b0010;
    set_alarm(1, 8, 0);
    set_alarm(5, 9, 0);
    H_in1 = 2'd2; H_in0 = 4'd5; M_in1 = 4'd0; M_in0 = 4'd0;
    AL_SEL = 3'd1; LD_alarm = 1; cyc(1); LD_alarm = 0;
    set_time(7, 59);
    cyc(120);
    check("sel5_ignored", 32'({Alarm, AL_RING}), 32'b10010);
    check("sel5_time", 32'(tvec()), 32'(bcd(8, 0, 0)));

    #2 reset_n = 0;
    #1;
    check("async_rst_alarm", 32'({Alarm, AL_RING}), 32'h0);
    check("async_rst_time", 32'(tvec()), 32'(bcd(0, 0, 0)));
    cyc(3);
    reset_n = 1;
    cyc(2);
    check("post_rst_time", 32'(tvec()), 32'(bcd(0, 0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
